// File: rtl/conv_weight_bank.sv
// Double-buffered KSIZE x KSIZE convolution weight store: beats stream into a shadow bank,
// then commit copies the whole kernel to the active bank. Optional readback: WEIGHT_READBACK_EN.
module conv_weight_bank #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 5,
    parameter int CNT_W  = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_load_start,
    input  logic                            i_w_valid,
    input  logic [DATA_W-1:0]               i_w,
    output logic                            o_w_ready,
    output logic                            o_load_done,
    input  logic                            i_commit,
    input  logic                            i_clear,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   o_w_bank,
    output logic                            o_bank_valid,
    output logic                            o_busy,
    output logic [1:0]                      o_dbg_state
`ifdef WEIGHT_READBACK_EN
    ,
    input  logic                            i_rd_en,
    input  logic [CNT_W-1:0]                i_rd_addr,
    output logic [DATA_W-1:0]               o_rd_data,
    output logic                            o_rd_valid
`endif
);

    localparam int TAPS = KSIZE * KSIZE;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2
    } state_t;

    // Handshake: a beat transfers on a rising edge where i_w_valid && o_w_ready,
    // except when i_load_start or i_clear is high in that cycle (the beat is dropped).
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               beat_we;
    logic               commit_go;
    logic [DATA_W-1:0]  shadow [TAPS];

    assign o_dbg_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat_we   = 1'b0;
        commit_go = 1'b0;
        if (i_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (i_load_start) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (i_w_valid) begin
                        beat_we = 1'b1;
                        if (cnt == LAST_TAP) begin
                            state_nxt = LOADED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                LOADED: begin
                    if (i_commit) begin
                        commit_go = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags are decoded from the next state so they stay pure registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_w_ready    <= 1'b0;
            o_load_done  <= 1'b0;
            o_busy       <= 1'b0;
            o_w_bank     <= '0;
            o_bank_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            o_w_ready   <= (state_nxt == LOAD);
            o_busy      <= (state_nxt == LOAD);
            o_load_done <= (state_nxt == LOADED);
            if (i_clear) begin
                o_w_bank     <= '0;
                o_bank_valid <= 1'b0;
            end else if (commit_go) begin
                for (int t = 0; t < TAPS; t++) begin
                    o_w_bank[t*DATA_W +: DATA_W] <= shadow[t];
                end
                o_bank_valid <= 1'b1;
            end
        end
    end

    // Shadow bank is plain storage: neither reset nor clear touches it.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && beat_we) begin
            shadow[cnt] <= i_w;
        end
    end

`ifdef WEIGHT_READBACK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= (int'(i_rd_addr) < TAPS) ? shadow[i_rd_addr] : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_weight_bank.sv
// Directed bench for conv_weight_bank; readback checks are built only with WEIGHT_READBACK_EN.
module tb_conv_weight_bank;

    localparam int DATA_W = 8;
    localparam int KSIZE  = 5;
    localparam int CNT_W  = 5;
    localparam int TAPS   = KSIZE * KSIZE;
    localparam int BW     = TAPS * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic              w_valid;
    logic [DATA_W-1:0] w;
    logic              w_ready;
    logic              load_done;
    logic              commit;
    logic              clear;
    logic [BW-1:0]     w_bank;
    logic              bank_valid;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef WEIGHT_READBACK_EN
    logic              rd_en;
    logic [CNT_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`endif

    int total = 0;
    int bad   = 0;

    conv_weight_bank #(.DATA_W(DATA_W), .KSIZE(KSIZE), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_start (load_start),
        .i_w_valid    (w_valid),
        .i_w          (w),
        .o_w_ready    (w_ready),
        .o_load_done  (load_done),
        .i_commit     (commit),
        .i_clear      (clear),
        .o_w_bank     (w_bank),
        .o_bank_valid (bank_valid),
        .o_busy       (busy),
        .o_dbg_state  (dbg_state)
`ifdef WEIGHT_READBACK_EN
        ,
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] wval(input int mode, input int i);
        case (mode)
            0:       return DATA_W'(i - 12);
            1:       return DATA_W'(3 * i + 1);
            2:       return 8'h7F;
            3:       return 8'h01;
            4:       return 8'h02;
            default: return DATA_W'(2 * i - 20);
        endcase
    endfunction

    function automatic logic [BW-1:0] bank_of(input int mode);
        logic [BW-1:0] r;
        r = '0;
        for (int t = 0; t < TAPS; t++) r[t*DATA_W +: DATA_W] = wval(mode, t);
        return r;
    endfunction

    // driver tasks
    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic stream(input int mode, input int n, input int first);
        for (int i = 0; i < n; i++) begin
            w_valid = 1'b1;
            w       = wval(mode, first + i);
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    int accepted;

    initial begin
        rst_n = 1'b0; load_start = 1'b0; w_valid = 1'b0; w = '0;
        commit = 1'b0; clear = 1'b0;
`ifdef WEIGHT_READBACK_EN
        rd_en = 1'b0; rd_addr = '0;
`endif
        tick(); tick();
        chk("rst_bank", w_bank, '0);
        chk("rst_bank_valid", bank_valid, 0);
        chk("rst_ready", w_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
`ifdef WEIGHT_READBACK_EN
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
`endif
        rst_n = 1'b1;
        tick();

        // ramp kernel -12..12, continuous valid
        start_load();
        chk("start_ready", w_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_state", dbg_state, 1);
        stream(0, 24, 0);
        chk("ramp_done_early", load_done, 0);
        stream(0, 1, 24);
        chk("ramp_done", load_done, 1);
        chk("ramp_ready_off", w_ready, 0);
        chk("ramp_busy_off", busy, 0);
        chk("ramp_not_committed", w_bank, '0);
        do_commit();
        chk("ramp_tap0", w_bank[7:0], 8'hF4);
        chk("ramp_tap24", w_bank[199:192], 8'h0C);
        chk("ramp_bank", w_bank, bank_of(0));
        chk("ramp_bank_valid", bank_valid, 1);
        chk("ramp_done_clr", load_done, 0);
        chk("ramp_state_idle", dbg_state, 0);

        // valid toggled every other cycle, stray commit mid-load
        start_load();
        accepted = 0;
        for (int cyc = 0; cyc < 100 && accepted < TAPS; cyc++) begin
            w_valid = (cyc % 2 == 0);
            w       = wval(1, accepted);
            commit  = (cyc == 7);
            tick();
            commit = 1'b0;
            if (w_valid) accepted++;
            if (cyc == 7) chk("toggle_commit_ignored", w_bank, bank_of(0));
            if (accepted == TAPS - 1) chk("toggle_done_early", load_done, 0);
        end
        w_valid = 1'b0;
        chk("toggle_accepted", accepted, TAPS);
        chk("toggle_done", load_done, 1);
        do_commit();
        chk("toggle_bank", w_bank, bank_of(1));

        // kernel B = 0x7F while the previous kernel stays active
        start_load();
        stream(2, 12, 0);
        chk("hold_mid", w_bank, bank_of(1));
        stream(2, 13, 12);
        chk("hold_loaded_done", load_done, 1);
        chk("hold_loaded", w_bank, bank_of(1));
        do_commit();
        chk("b_bank", w_bank, bank_of(2));
        chk("b_valid", bank_valid, 1);

        // back-to-back start, restart at beat 10 with a dropped beat
        start_load();
        chk("b2b_ready", w_ready, 1);
        chk("b2b_hold", w_bank, bank_of(2));
        stream(5, 10, 0);
        load_start = 1'b1; w_valid = 1'b1; w = 8'h66;
        tick();
        load_start = 1'b0; w_valid = 1'b0;
        chk("restart_state", dbg_state, 1);
        stream(3, 24, 0);
        chk("restart_done_early", load_done, 0);
        stream(3, 1, 24);
        chk("restart_done", load_done, 1);
        do_commit();
        chk("restart_bank", w_bank, bank_of(3));

        // commit and start together in LOADED: restart wins
        start_load();
        stream(4, 25, 0);
        chk("cs_done", load_done, 1);
        commit = 1'b1; load_start = 1'b1;
        tick();
        commit = 1'b0; load_start = 1'b0;
        chk("cs_state", dbg_state, 1);
        chk("cs_ready", w_ready, 1);
        chk("cs_done_clr", load_done, 0);
        chk("cs_no_commit", w_bank, bank_of(3));

        // clear mid-load
        stream(4, 5, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_bank", w_bank, '0);
        chk("clr_valid", bank_valid, 0);
        chk("clr_ready", w_ready, 0);
        chk("clr_busy", busy, 0);
        chk("clr_state", dbg_state, 0);

`ifdef WEIGHT_READBACK_EN
        start_load();
        stream(5, 25, 0);
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        chk("rd_tap3", rd_data, 8'hF2);
        chk("rd_valid", rd_valid, 1);
        rd_addr = 5'd30;
        tick();
        chk("rd_oob", rd_data, 0);
        rd_en = 1'b0;
        tick();
        chk("rd_valid_off", rd_valid, 0);
        do_commit();
        chk("rd_commit", w_bank, bank_of(5));
`endif

        // reset mid-load with a committed kernel
        start_load();
        stream(0, 25, 0);
        do_commit();
        chk("pre_rst_bank", w_bank, bank_of(0));
        start_load();
        stream(2, 5, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_bank", w_bank, '0);
        chk("mrst_valid", bank_valid, 0);
        chk("mrst_ready", w_ready, 0);
        chk("mrst_done", load_done, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_state", dbg_state, 0);
`ifdef WEIGHT_READBACK_EN
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_rd_valid", rd_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_weight_bank.md
# conv_weight_bank

Double-buffered, parametrised convolution weight store: streams a KSIZE×KSIZE kernel of signed DATA_W-bit weights into a shadow bank through a valid/ready handshake, then commits the whole kernel atomically to an active bank driven to the MAC array. The active kernel stays stable while the next kernel loads, so convolution never pauses for a weight update. It sits between the weight loader/DMA and the convolution datapath, generalising the fixed 25-tap, 8-bit weight register file.

## Interface
Parameters:
- DATA_W, 8, weight width in bits (signed, two's complement)
- KSIZE, 5, kernel edge; TAPS = KSIZE*KSIZE
- CNT_W, 5, tap counter/address width; must satisfy 2^CNT_W ≥ TAPS

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_load_start  in  1  begin a new kernel load into the shadow bank
- i_w_valid  in  1  weight beat valid
- i_w  in  DATA_W  signed weight beat, raster order (tap 0 first)
- o_w_ready  out  1  block accepts a beat
- o_load_done  out  1  shadow bank holds a complete kernel
- i_commit  in  1  copy shadow bank to active bank
- i_clear  in  1  zero active bank, abort any load
- o_w_bank  out  TAPS*DATA_W  active kernel, tap t at bits [t*DATA_W +: DATA_W]
- o_bank_valid  out  1  active bank holds a committed kernel
- o_busy  out  1  load in progress
- i_rd_en, i_rd_addr[CNT_W], o_rd_data[DATA_W], o_rd_valid  readback port (only with WEIGHT_READBACK_EN)

## Operation
- FSM states: IDLE, LOAD, LOADED.
- IDLE: o_w_ready=0. i_load_start → LOAD, tap counter cnt=0.
- LOAD: o_w_ready=1, o_busy=1. Each cycle with i_w_valid && o_w_ready writes i_w to shadow[cnt], cnt++. The beat at cnt==TAPS-1 → LOADED, cnt=0.
- LOADED: o_w_ready=0, o_load_done=1. i_commit → active bank ← shadow bank, o_bank_valid=1, → IDLE.
- i_load_start in LOAD or LOADED restarts: cnt=0, → LOAD; any beat presented in that same cycle is dropped (o_w_ready has no effect that cycle); the shadow contents are left stale until overwritten.
- i_commit outside LOADED is ignored; a partially loaded kernel is never committed.
- i_clear: all active taps=0, o_bank_valid=0, cnt=0, → IDLE. Shadow bank is not cleared.
- Priority: reset > i_clear > i_load_start > i_commit > beat write.
- The active bank changes only on commit, clear, or reset; i_w_valid low does not zero outputs.
- Weights pass bit-exact; no sign extension or saturation.

## Timing
- Reset (i_rst_n=0 at an edge): o_w_bank=0, o_bank_valid=0, o_w_ready=0, o_load_done=0, o_busy=0, o_rd_data=0, o_rd_valid=0, state IDLE, cnt=0. Reset mid-load discards the load.
- i_load_start at edge N → o_w_ready=1 from cycle N+1.
- Beat throughput 1/cycle; a full kernel takes TAPS accepted beats; o_load_done=1 the cycle after the last beat.
- i_commit sampled in LOADED at edge N → new o_w_bank and o_bank_valid=1 visible at cycle N+1; o_load_done=0 at N+1.
- i_commit and i_load_start in the same LOADED cycle: restart wins, no commit.
- Back-to-back: i_load_start may be asserted in the cycle after the commit edge; the active bank holds the committed kernel throughout the next load.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- WEIGHT_READBACK_EN defined: readback port present. i_rd_en at edge N → o_rd_data=shadow[i_rd_addr], o_rd_valid=1 at N+1 (otherwise o_rd_valid=0). i_rd_addr ≥ TAPS returns 0. Readback may run in any state; reading the tap being written in the same cycle returns the old value.
- Not defined: readback ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then load taps 0..24 = −12..12 (DATA_W=8, KSIZE=5) with continuous valid, then commit → o_load_done=1 after the 25th beat; next cycle o_w_bank tap0=0xF4, tap24=0x0C, o_bank_valid=1.
- Load with i_w_valid toggled every other cycle → exactly 25 beats accepted and o_load_done rises only after the 25th; issuing i_commit during LOAD leaves o_w_bank unchanged.
- With kernel A committed, load kernel B (all 0x7F) → o_w_bank stays A until the commit edge, then every tap = 0x7F one cycle later.
- Assert i_load_start at beat 10, then stream 25 beats of 0x01 → commit yields all taps 0x01; and i_commit together with i_load_start in LOADED → no commit, state LOAD.
- i_clear mid-load with a committed kernel → o_w_bank=0, o_bank_valid=0, o_w_ready=0 next cycle; i_rst_n low for one cycle mid-load → all outputs at reset values.
- WEIGHT_READBACK_EN: after loading, read addr 3 → o_rd_data equals tap 3 one cycle later; read addr 30 → 0.
